// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: scan sequencer for the 1-bit VGA pixel renderer.
//   Two phase FSMs (horizontal and vertical) step through active, front
//   porch, sync and back porch. The block exports pixel coordinates, the
//   glyph row, and a fetch strobe that fires one clock before each visible
//   character cell starts, so the glyph lookup has one cycle to respond.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset; also forces outputs idle
//   hsync/vsync  sync outputs, active level selected by SYNC_NEG
//   de           display enable for the pixel (x,y) shown this cycle
//   x, y         scan counters, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   glyph_row    y mod CHAR_H
//   fetch_stb    next clock is the first pixel of a visible cell
//   fetch_col/fetch_row  cell about to start; held between strobes
//   frame_start  pulse at x=0, y=0
//   frame_cnt    frame counter, built only with VGA_FRAME_COUNT_EN defined;
//                otherwise tied to 0
//
// Config macro: VGA_FRAME_COUNT_EN

module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_NEG = 1,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [9:0]                x,
  output logic [9:0]                y,
  output logic [$clog2(CHAR_H)-1:0] glyph_row,
  output logic                      fetch_stb,
  output logic [6:0]                fetch_col,
  output logic [5:0]                fetch_row,
  output logic                      frame_start,
  output logic [7:0]                frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int GW      = $clog2(CHAR_H);

  // last counter value of each phase
  localparam logic [9:0] X_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] X_FP_END   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] X_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] Y_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] Y_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);

  // CHAR_W is a power of two, so x mod CHAR_W is a mask
  localparam logic [9:0]    CW_MASK = 10'(CHAR_W - 1);
  localparam logic [GW-1:0] G_LAST  = GW'(CHAR_H - 1);
  localparam logic          SYNC_ACT = (SYNC_NEG == 0);

  typedef enum logic [1:0] {H_ACT_ST, H_FP_ST, H_SYNC_ST, H_BP_ST} h_state_t;
  typedef enum logic [1:0] {V_ACT_ST, V_FP_ST, V_SYNC_ST, V_BP_ST} v_state_t;

  h_state_t        h_state, h_next;
  v_state_t        v_state, v_next;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [6:0]      col_q, col_d, fcol_q, fcol_nx;
  logic [5:0]      row_q, row_d, frow_q, frow_nx;
  logic [GW-1:0]   glyph_q, glyph_d;
  logic            line_end, frame_end, cell_end, stb_a, stb_b, stb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_state <= H_ACT_ST;
      v_state <= V_ACT_ST;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      glyph_q <= '0;
      fcol_q  <= '0;
      frow_q  <= '0;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      glyph_q <= glyph_d;
      if (stb) begin
        fcol_q <= fcol_nx;
        frow_q <= frow_nx;
      end
    end
  end

  always_comb begin
    line_end  = (x_q == X_LAST);
    frame_end = line_end && (y_q == Y_LAST);
    cell_end  = ((x_q & CW_MASK) == CW_MASK);

    // horizontal
    x_d    = line_end ? '0 : x_q + 10'd1;
    col_d  = line_end ? '0 : (cell_end ? col_q + 7'd1 : col_q);
    h_next = h_state;
    case (h_state)
      H_ACT_ST:  if (x_q == X_ACT_END)  h_next = H_FP_ST;
      H_FP_ST:   if (x_q == X_FP_END)   h_next = H_SYNC_ST;
      H_SYNC_ST: if (x_q == X_SYNC_END) h_next = H_BP_ST;
      H_BP_ST:   if (line_end)          h_next = H_ACT_ST;
      default:                          h_next = H_ACT_ST;
    endcase

    // vertical: everything moves only on the line wrap
    y_d     = y_q;
    glyph_d = glyph_q;
    row_d   = row_q;
    v_next  = v_state;
    if (line_end) begin
      y_d     = frame_end ? '0 : y_q + 10'd1;
      glyph_d = frame_end ? '0 : glyph_q + GW'(1);
      row_d   = frame_end ? '0 : ((glyph_q == G_LAST) ? row_q + 6'd1 : row_q);
      case (v_state)
        V_ACT_ST:  if (y_q == Y_ACT_END)  v_next = V_FP_ST;
        V_FP_ST:   if (y_q == Y_FP_END)   v_next = V_SYNC_ST;
        V_SYNC_ST: if (y_q == Y_SYNC_END) v_next = V_BP_ST;
        V_BP_ST:   if (y_q == Y_LAST)     v_next = V_ACT_ST;
        default:                          v_next = V_ACT_ST;
      endcase
    end

    // a: next cell on this visible line; b: first cell of the next line,
    // which must itself be visible (the frame wrap lands on line 0)
    stb_a = (h_state == H_ACT_ST) && (v_state == V_ACT_ST) &&
            (x_q < X_ACT_END) && cell_end;
    stb_b = line_end && ((y_q < Y_ACT_END) || (y_q == Y_LAST));
    stb   = rst_n && (stb_a || stb_b);

    // row_d already holds next line's cell row when stb_b fires
    fcol_nx = stb_a ? col_q + 7'd1 : '0;
    frow_nx = stb_a ? row_q : row_d;
  end

  assign de          = rst_n && (h_state == H_ACT_ST) && (v_state == V_ACT_ST);
  assign hsync       = (rst_n && (h_state == H_SYNC_ST)) ? SYNC_ACT : ~SYNC_ACT;
  assign vsync       = (rst_n && (v_state == V_SYNC_ST)) ? SYNC_ACT : ~SYNC_ACT;
  assign x           = rst_n ? x_q : '0;
  assign y           = rst_n ? y_q : '0;
  assign glyph_row   = glyph_q;
  assign fetch_stb   = stb;
  assign fetch_col   = stb ? fcol_nx : fcol_q;
  assign fetch_row   = stb ? frow_nx : frow_q;
  assign frame_start = rst_n && (x_q == '0) && (y_q == '0);

`ifdef VGA_FRAME_COUNT_EN
  // bumps as the last pixel of a frame retires, so frame n reads n
  logic [7:0] fcnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)         fcnt_q <= '0;
    else if (frame_end) fcnt_q <= fcnt_q + 8'd1;
  end
  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunk raster (40x36 totals, 32x32 visible,
// 8x16 cells) so whole frames fit in a short run. Directed table first,
// then a per-cycle sweep against a timing model, then a mid-frame reset.
module tb_vga_scan_ctrl;
  localparam int HA = 32, HF = 2, HS = 4, HB = 2;
  localparam int VA = 32, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 40
  localparam int VT = VA + VF + VS + VB;  // 36
  localparam int FT = HT * VT;            // 1440

  logic       clk, rst_n;
  logic       hsync, vsync, de, fetch_stb, frame_start;
  logic [9:0] x, y;
  logic [3:0] glyph_row;
  logic [6:0] fetch_col;
  logic [5:0] fetch_row;
  logic [7:0] frame_cnt;

  int checks = 0, errors = 0;

  vga_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .SYNC_NEG(1), .CHAR_W(8), .CHAR_H(16)) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .glyph_row(glyph_row), .fetch_stb(fetch_stb),
    .fetch_col(fetch_col), .fetch_row(fetch_row),
    .frame_start(frame_start), .frame_cnt(frame_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst;
    int   adv;
    int   ex, ey;
    logic ede, ehs, evs, efs, estb;
  } vec_t;

  vec_t vt[11];

  // timing model over time t counted from reset release
  int   t, ex, ey, ecol, erow;
  logic e_de, e_hs, e_vs, e_fs, e_stb;
  int   fs_prev, stb_frame1, stb_blank;

  task automatic model(input int tt);
    ex   = tt % HT;
    ey   = (tt / HT) % VT;
    e_de = (ex < HA) && (ey < VA);
    e_hs = !((ex >= HA + HF) && (ex < HA + HF + HS));
    e_vs = !((ey >= VA + VF) && (ey < VA + VF + VS));
    e_fs = (ex == 0) && (ey == 0);
    e_stb = ((ey < VA) && (ex < HA - 1) && (ex % 8 == 7)) ||
            ((ex == HT - 1) && ((ey < VA - 1) || (ey == VT - 1)));
    ecol = (ex == HT - 1) ? 0 : (ex + 1) / 8;
    erow = (ex == HT - 1) ? ((ey + 1) % VT) / 16 : ey / 16;
  endtask

  initial begin
    //          rst adv  x   y  de hs vs fs stb
    vt[0]  = '{1'b0, 3,  0, 0, 0, 1, 1, 0, 0};
    vt[1]  = '{1'b1, 0,  0, 0, 1, 1, 1, 1, 0};
    vt[2]  = '{1'b1, 7,  7, 0, 1, 1, 1, 0, 1};
    vt[3]  = '{1'b1, 1,  8, 0, 1, 1, 1, 0, 0};
    vt[4]  = '{1'b1, 23, 31, 0, 1, 1, 1, 0, 0};
    vt[5]  = '{1'b1, 1,  32, 0, 0, 1, 1, 0, 0};
    vt[6]  = '{1'b1, 2,  34, 0, 0, 0, 1, 0, 0};
    vt[7]  = '{1'b1, 3,  37, 0, 0, 0, 1, 0, 0};
    vt[8]  = '{1'b1, 1,  38, 0, 0, 1, 1, 0, 0};
    vt[9]  = '{1'b1, 1,  39, 0, 0, 1, 1, 0, 1};
    vt[10] = '{1'b1, 1,  0, 1, 1, 1, 1, 0, 0};

    rst_n = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rst_n = vt[i].rst;
      if (vt[i].adv > 0) step(vt[i].adv);
      else #1;
      chk($sformatf("vec%0d_x", i), int'(x), vt[i].ex);
      chk($sformatf("vec%0d_y", i), int'(y), vt[i].ey);
      chk($sformatf("vec%0d_de", i), int'(de), int'(vt[i].ede));
      chk($sformatf("vec%0d_hsync", i), int'(hsync), int'(vt[i].ehs));
      chk($sformatf("vec%0d_vsync", i), int'(vsync), int'(vt[i].evs));
      chk($sformatf("vec%0d_frame_start", i), int'(frame_start), int'(vt[i].efs));
      chk($sformatf("vec%0d_fetch_stb", i), int'(fetch_stb), int'(vt[i].estb));
    end
    chk("vec2_fetch_col", int'(fetch_col), 0);  // held from x=39 strobe

    // sweep frames from t=40 (x=0,y=1) until the start of frame 3
    fs_prev = 0; stb_frame1 = 0; stb_blank = 0;
    for (t = 40; t < 3 * FT; t++) begin
      model(t);
      chk("sw_x", int'(x), ex);
      chk("sw_y", int'(y), ey);
      chk("sw_de", int'(de), int'(e_de));
      chk("sw_hsync", int'(hsync), int'(e_hs));
      chk("sw_vsync", int'(vsync), int'(e_vs));
      chk("sw_frame_start", int'(frame_start), int'(e_fs));
      chk("sw_glyph_row", int'(glyph_row), ey % 16);
      chk("sw_fetch_stb", int'(fetch_stb), int'(e_stb));
      if (e_stb) begin
        chk("sw_fetch_col", int'(fetch_col), ecol);
        chk("sw_fetch_row", int'(fetch_row), erow);
      end
      if (t == 15 * HT + HT - 1) chk("line15_fetch_row", int'(fetch_row), 1);
      if (t >= FT && t < 2 * FT && fetch_stb) stb_frame1++;
      if (ey >= VA && ey < VT - 1 && fetch_stb) stb_blank++;
      if (frame_start) begin
        chk("frame_period", t - fs_prev, FT);
        fs_prev = t;
      end
`ifdef VGA_FRAME_COUNT_EN
      if (e_fs) chk("frame_cnt", int'(frame_cnt), (t / FT) % 256);
`else
      chk("frame_cnt_zero", int'(frame_cnt), 0);
`endif
      step(1);
    end
    chk("strobes_frame1", stb_frame1, VA * (HA / 8));
    chk("strobes_blank", stb_blank, 0);

    // mid-frame reset inside both sync pulses: x=36, y=33
    step(33 * HT + 36);
    chk("mid_x", int'(x), 36);
    chk("mid_y", int'(y), 33);
    chk("mid_hsync_act", int'(hsync), 0);
    chk("mid_vsync_act", int'(vsync), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_force_hsync", int'(hsync), 1);
    chk("rst_force_vsync", int'(vsync), 1);
    chk("rst_force_de", int'(de), 0);
    chk("rst_force_x", int'(x), 0);
    chk("rst_force_stb", int'(fetch_stb), 0);
    step(1);
    chk("rst_edge_hsync", int'(hsync), 1);
    chk("rst_edge_de", int'(de), 0);
    chk("rst_edge_fs", int'(frame_start), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_x", int'(x), 0);
    chk("rel_y", int'(y), 0);
    chk("rel_de", int'(de), 1);
    chk("rel_fs", int'(frame_start), 1);
    chk("rel_hsync", int'(hsync), 1);
    chk("rel_vsync", int'(vsync), 1);
    chk("rel_frame_cnt", int'(frame_cnt), 0);
    step(HT);
    chk("rel_line1_x", int'(x), 0);
    chk("rel_line1_y", int'(y), 1);
    chk("rel_line1_glyph", int'(glyph_row), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
